paint_scheduler: RTL and testbench

Arbitration controller for the single-port pixel frame buffer. It shares the pixel memory port between three requesters:
- the VGA scan-out read, which has absolute priority during active video;
- a screen-clear sweep engine;
- a small FIFO of decoded SPI paint commands.

It sits between the SPI packet decoder and the pixel store. It also holds the brush cursor registers consumed by the color decoder.

---
 rtl/paint_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_paint_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/paint_scheduler.sv
// paint_scheduler: shares the single-port frame buffer between VGA scan-out, a clear sweep and queued SPI paint commands.
// mem_* is registered one cycle after arbitration; cmd_ready = !fifo_full. Sweep engine built only with PAINT_SCHEDULER_CLEAR_EN.
module paint_scheduler #(
  parameter int XW          = 10,
  parameter int YW          = 10,
  parameter int CW          = 3,
  parameter int DEPTH       = 4,
  parameter int XMAX        = 640,
  parameter int YMAX        = 480,
  parameter int CLEAR_COLOR = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [XW-1:0] cmd_x,
  input  logic [YW-1:0] cmd_y,
  input  logic [CW-1:0] cmd_color,
  input  logic          cmd_brush,
  input  logic          cmd_clear,
  input  logic          active,
  input  logic [XW-1:0] vga_x,
  input  logic [YW-1:0] vga_y,
  output logic [XW-1:0] mem_x,
  output logic [YW-1:0] mem_y,
  output logic          mem_we,
  output logic [CW-1:0] mem_wdata,
  output logic [XW-1:0] cur_x,
  output logic [YW-1:0] cur_y,
  output logic [CW-1:0] cur_color,
  output logic          clr_busy,
  output logic          clr_done
);
  localparam int          AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [XW:0] XLIM  = (XW+1)'(XMAX);
  localparam logic [YW:0] YLIM  = (YW+1)'(YMAX);
  localparam logic [CW-1:0] CLR_C = CW'(CLEAR_COLOR);

  typedef struct packed {
    logic          brush;
    logic [CW-1:0] color;
    logic [YW-1:0] y;
    logic [XW-1:0] x;
  } cmd_t;

  cmd_t          fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push, pop, full, empty, in_range, drain_ok;
  cmd_t          head;

  logic          sweep_on;
  logic [XW-1:0] sweep_x;
  logic [YW-1:0] sweep_y;
  logic [CW-1:0] sweep_c;

  logic [XW-1:0] mem_x_q, mem_x_d, cur_x_q, cur_x_d;
  logic [YW-1:0] mem_y_q, mem_y_d, cur_y_q, cur_y_d;
  logic [CW-1:0] mem_wdata_q, mem_wdata_d, cur_color_q, cur_color_d;
  logic          mem_we_q, mem_we_d;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = fifo_q[rd_ptr_q];
  assign pop       = !active && drain_ok && !empty;
  assign in_range  = ({1'b0, head.x} < XLIM) && ({1'b0, head.y} < YLIM);

`ifdef PAINT_SCHEDULER_CLEAR_EN
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [XW-1:0] XLAST = XW'(XMAX - 1);
  localparam logic [YW-1:0] YLAST = YW'(YMAX - 1);

  logic [1:0]    state_q, state_d;
  logic [XW-1:0] sx_q, sx_d;
  logic [YW-1:0] sy_q, sy_d;
  logic          done_q;

  always_comb begin
    state_d = state_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    case (state_q)
      S_IDLE: if (cmd_clear) begin
        state_d = S_SWEEP;
        sx_d    = '0;
        sy_d    = '0;
      end
      S_SWEEP: if (!active) begin
        if (sx_q == XLAST) begin
          sx_d = '0;
          if (sy_q == YLAST) state_d = S_DONE;
          else               sy_d    = sy_q + 1'b1;
        end else begin
          sx_d = sx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sx_q    <= '0;
      sy_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      done_q  <= (state_q == S_DONE);
    end
  end

  // Queue stays parked until the done pulse has been seen, so queued paint lands after the clear.
  assign drain_ok = (state_q == S_IDLE) && !done_q;
  assign sweep_on = (state_q == S_SWEEP);
  assign sweep_x  = sx_q;
  assign sweep_y  = sy_q;
  assign clr_busy = sweep_on;
  assign clr_done = done_q;
`else
  logic unused_clr;
  assign unused_clr = cmd_clear;
  assign drain_ok   = 1'b1;
  assign sweep_on   = 1'b0;
  assign sweep_x    = '0;
  assign sweep_y    = '0;
  assign clr_busy   = 1'b0;
  assign clr_done   = 1'b0;
`endif
  assign sweep_c = CLR_C;

  always_comb begin
    mem_x_d     = mem_x_q;
    mem_y_d     = mem_y_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    cur_color_d = cur_color_q;
    if (active) begin
      mem_x_d = vga_x;
      mem_y_d = vga_y;
    end else if (sweep_on) begin
      mem_x_d     = sweep_x;
      mem_y_d     = sweep_y;
      mem_wdata_d = sweep_c;
      mem_we_d    = 1'b1;
    end else if (pop) begin
      if (head.brush) begin
        cur_x_d     = head.x;
        cur_y_d     = head.y;
        cur_color_d = head.color;
      end else if (in_range) begin
        mem_x_d     = head.x;
        mem_y_d     = head.y;
        mem_wdata_d = head.color;
        mem_we_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{brush: cmd_brush, color: cmd_color, y: cmd_y, x: cmd_x};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mem_x_q     <= '0;
      mem_y_q     <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      cur_color_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      mem_x_q     <= mem_x_d;
      mem_y_q     <= mem_y_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      cur_color_q <= cur_color_d;
    end
  end

  assign mem_x     = mem_x_q;
  assign mem_y     = mem_y_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign cur_x     = cur_x_q;
  assign cur_y     = cur_y_q;
  assign cur_color = cur_color_q;
endmodule

// File: tb/tb_paint_scheduler.sv
// Directed bench: full-size instance for command paths, 4x2 instance for the clear sweep and mid-sweep reset.
module tb_paint_scheduler;
`ifdef PAINT_SCHEDULER_CLEAR_EN
  localparam int NSW = 8;
  localparam bit EXP_BUSY = 1'b1;
  localparam int EXP_DONE = 1;
`else
  localparam int NSW = 0;
  localparam bit EXP_BUSY = 1'b0;
  localparam int EXP_DONE = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic cmd_valid, cmd_brush, cmd_clear, active;
  logic [9:0] cmd_x, vga_x;
  logic [9:0] cmd_y, vga_y;
  logic [2:0] cmd_color;

  logic cmd_ready, mem_we, clr_busy, clr_done;
  logic [9:0] mem_x, mem_y, cur_x, cur_y;
  logic [2:0] mem_wdata, cur_color;

  logic s_cmd_ready, s_mem_we, s_clr_busy, s_clr_done;
  logic [9:0] s_mem_x, s_mem_y, s_cur_x, s_cur_y;
  logic [2:0] s_mem_wdata, s_cur_color;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  paint_scheduler u_dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_color(cmd_color), .cmd_brush(cmd_brush),
    .cmd_clear(cmd_clear), .active(active), .vga_x(vga_x), .vga_y(vga_y),
    .mem_x(mem_x), .mem_y(mem_y), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .cur_x(cur_x), .cur_y(cur_y), .cur_color(cur_color),
    .clr_busy(clr_busy), .clr_done(clr_done)
  );

  paint_scheduler #(.XMAX(4), .YMAX(2)) u_sml (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_color(cmd_color), .cmd_brush(cmd_brush),
    .cmd_clear(cmd_clear), .active(active), .vga_x(vga_x), .vga_y(vga_y),
    .mem_x(s_mem_x), .mem_y(s_mem_y), .mem_we(s_mem_we), .mem_wdata(s_mem_wdata),
    .cur_x(s_cur_x), .cur_y(s_cur_y), .cur_color(s_cur_color),
    .clr_busy(s_clr_busy), .clr_done(s_clr_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; cmd_valid = 1'b0; cmd_brush = 1'b0; cmd_clear = 1'b0; active = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_color = '0; vga_x = '0; vga_y = '0;
    repeat (2) step();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
    total++; if ({mem_we, mem_x, mem_y, mem_wdata} !== 24'h0) begin bad++; $display("FAIL rst_mem: got %h want 0", {mem_we, mem_x, mem_y, mem_wdata}); end
    total++; if ({cur_x, cur_y, cur_color} !== 23'h0) begin bad++; $display("FAIL rst_cur: got %h want 0", {cur_x, cur_y, cur_color}); end
    total++; if ({clr_busy, clr_done, s_clr_busy, s_clr_done} !== 4'b0) begin bad++; $display("FAIL rst_clr: got %b want 0000", {clr_busy, clr_done, s_clr_busy, s_clr_done}); end
    reset = 1'b1;
    step();
    total++; if ({cmd_ready, mem_we, s_cmd_ready, s_mem_we} !== 4'b1010) begin bad++; $display("FAIL rst_release: got %b want 1010", {cmd_ready, mem_we, s_cmd_ready, s_mem_we}); end
  endtask

  task automatic test_single_pixel();
    cmd_valid = 1'b1; cmd_brush = 1'b0; cmd_x = 10'd12; cmd_y = 10'd34; cmd_color = 3'd5;
    step();
    cmd_valid = 1'b0;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL pix_early: got mem_we=%b want 0", mem_we); end
    step();
    total++; if ({mem_we, mem_x, mem_y, mem_wdata} !== {1'b1, 10'd12, 10'd34, 3'd5}) begin
      bad++; $display("FAIL pix_write: got we=%b x=%0d y=%0d c=%0d want 1/12/34/5", mem_we, mem_x, mem_y, mem_wdata);
    end
    step();
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL pix_once: got mem_we=%b want 0", mem_we); end
  endtask

  task automatic test_fifo_full();
    active = 1'b1; vga_x = 10'd7; vga_y = 10'd9;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_brush = 1'b0;
      cmd_x = 10'(i + 1); cmd_y = 10'(i + 10); cmd_color = 3'(i);
      total++; if (cmd_ready !== (i < 4)) begin bad++; $display("FAIL full_ready%0d: got %b want %b", i, cmd_ready, (i < 4)); end
      step();
    end
    cmd_valid = 1'b0;
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL full_hold: got %b want 0", cmd_ready); end
    total++; if ({mem_we, mem_x, mem_y} !== {1'b0, 10'd7, 10'd9}) begin
      bad++; $display("FAIL full_vga: got we=%b x=%0d y=%0d want 0/7/9", mem_we, mem_x, mem_y);
    end
    active = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if ({mem_we, mem_x, mem_y, mem_wdata} !== {1'b1, 10'(i + 1), 10'(i + 10), 3'(i)}) begin
        bad++; $display("FAIL drain%0d: got we=%b x=%0d y=%0d c=%0d want 1/%0d/%0d/%0d", i, mem_we, mem_x, mem_y, mem_wdata, i + 1, i + 10, i);
      end
      if (i == 0) begin
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL drain_ready: got %b want 1", cmd_ready); end
      end
    end
    step();
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL drain_end: got mem_we=%b want 0", mem_we); end
  endtask

  task automatic test_brush();
    cmd_valid = 1'b1; cmd_brush = 1'b1; cmd_x = 10'd100; cmd_y = 10'd200; cmd_color = 3'd3;
    step();
    cmd_valid = 1'b0; cmd_brush = 1'b0;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL brush_we0: got %b want 0", mem_we); end
    step();
    total++; if ({cur_x, cur_y, cur_color} !== {10'd100, 10'd200, 3'd3}) begin
      bad++; $display("FAIL brush_cur: got %0d/%0d/%0d want 100/200/3", cur_x, cur_y, cur_color);
    end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL brush_we1: got %b want 0", mem_we); end
    step();
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL brush_we2: got %b want 0", mem_we); end
  endtask

  task automatic test_out_of_range();
    cmd_valid = 1'b1; cmd_brush = 1'b0; cmd_x = 10'd640; cmd_y = 10'd5; cmd_color = 3'd2;
    step();
    cmd_x = 10'd639; cmd_y = 10'd479; cmd_color = 3'd6;
    step();
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL oor_x: got mem_we=%b want 0", mem_we); end
    cmd_x = 10'd5; cmd_y = 10'd480; cmd_color = 3'd1;
    step();
    cmd_valid = 1'b0;
    total++; if ({mem_we, mem_x, mem_y, mem_wdata} !== {1'b1, 10'd639, 10'd479, 3'd6}) begin
      bad++; $display("FAIL oor_edge: got we=%b x=%0d y=%0d c=%0d want 1/639/479/6", mem_we, mem_x, mem_y, mem_wdata);
    end
    step();
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL oor_y: got mem_we=%b want 0", mem_we); end
    step();
    active = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_x = 10'(i); cmd_y = 10'd0; cmd_color = 3'd1;
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL oor_empty%0d: got ready=%b want 1", i, cmd_ready); end
      step();
    end
    cmd_valid = 1'b0;
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL oor_refill: got ready=%b want 0", cmd_ready); end
    active = 1'b0;
    repeat (6) step();
  endtask

  task automatic test_clear();
    int k = 0;
    int done_cnt = 0;
    int w_last = -10;
    bit pix_seen = 1'b0;
    bit act_e;
    vga_x = '0; vga_y = '0;
    cmd_clear = 1'b1;
    step();
    cmd_clear = 1'b0;
    total++; if (s_clr_busy !== EXP_BUSY) begin bad++; $display("FAIL clr_busy: got %b want %b", s_clr_busy, EXP_BUSY); end
    for (int cyc = 0; cyc < 60 && !pix_seen; cyc++) begin
      active = ((cyc / 3) % 2) == 1;
      cmd_valid = (cyc == 1); cmd_brush = 1'b0; cmd_x = 10'd2; cmd_y = 10'd1; cmd_color = 3'd4;
      cmd_clear = (cyc == 4);
      act_e = active;
      step();
      total++; if (act_e && s_mem_we) begin bad++; $display("FAIL clr_active_wr: got write at cycle %0d want none", cyc); end
      if (s_clr_done) begin
        done_cnt++;
        total++; if (k != NSW || cyc != w_last + 1) begin
          bad++; $display("FAIL clr_done_time: got cycle %0d after %0d writes want cycle %0d after %0d", cyc, k, w_last + 1, NSW);
        end
      end
      if (s_mem_we && !act_e) begin
        if (k < NSW) begin
          total++; if ({s_mem_x, s_mem_y, s_mem_wdata} !== {10'(k % 4), 10'(k / 4), 3'd0}) begin
            bad++; $display("FAIL clr_wr%0d: got %0d/%0d/%0d want %0d/%0d/0", k, s_mem_x, s_mem_y, s_mem_wdata, k % 4, k / 4);
          end
          w_last = cyc;
          k++;
        end else begin
          total++; if ({s_mem_x, s_mem_y, s_mem_wdata} !== {10'd2, 10'd1, 3'd4} || done_cnt != EXP_DONE) begin
            bad++; $display("FAIL clr_queued: got %0d/%0d/%0d done=%0d want 2/1/4 done=%0d", s_mem_x, s_mem_y, s_mem_wdata, done_cnt, EXP_DONE);
          end
          pix_seen = 1'b1;
        end
      end
    end
    cmd_valid = 1'b0; cmd_clear = 1'b0; active = 1'b0;
    total++; if (!pix_seen) begin bad++; $display("FAIL clr_timeout: got no queued write want one"); end
    total++; if (k != NSW) begin bad++; $display("FAIL clr_count: got %0d want %0d", k, NSW); end
    total++; if (done_cnt != EXP_DONE) begin bad++; $display("FAIL clr_pulses: got %0d want %0d", done_cnt, EXP_DONE); end
    repeat (3) step();
  endtask

  task automatic test_reset_mid_sweep();
    active = 1'b0; cmd_clear = 1'b1;
    step();
    cmd_clear = 1'b0; active = 1'b1;
    cmd_valid = 1'b1; cmd_brush = 1'b0; cmd_x = 10'd1; cmd_y = 10'd0; cmd_color = 3'd7;
    step();
    cmd_x = 10'd2;
    step();
    cmd_valid = 1'b0; active = 1'b0;
    step();
    total++; if ({s_mem_we, s_clr_busy} !== {1'b1, EXP_BUSY}) begin
      bad++; $display("FAIL mid_pre: got we=%b busy=%b want 1/%b", s_mem_we, s_clr_busy, EXP_BUSY);
    end
    #2 reset = 1'b0;
    #1;
    total++; if ({s_mem_we, s_clr_busy, s_cmd_ready} !== 3'b001) begin
      bad++; $display("FAIL mid_async: got we=%b busy=%b ready=%b want 0/0/1", s_mem_we, s_clr_busy, s_cmd_ready);
    end
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      total++; if ({s_mem_we, s_clr_busy, s_clr_done} !== 3'b000) begin
        bad++; $display("FAIL mid_after%0d: got we=%b busy=%b done=%b want 0/0/0", i, s_mem_we, s_clr_busy, s_clr_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_fifo_full();
    test_brush();
    test_out_of_range();
    test_clear();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
